// File: rtl/vga_timing_receiver_if.sv
// Sync/pixel bus between a VGA timing source and the timing receiver.
// master: drives p_tick/hsync/vsync/rgb and observes the recovered stream.
// slave:  the receiver.
interface vga_timing_receiver_if;
   logic        p_tick;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;
   logic [9:0]  x;
   logic [9:0]  y;
   logic [11:0] pix_rgb;
   logic        pix_valid;
   logic        frame_start;
   logic        locked;
   logic [7:0]  err_cnt;
   logic [15:0] frame_crc;
   logic        crc_valid;

   modport master (
      output p_tick, hsync, vsync, rgb,
      input  x, y, pix_rgb, pix_valid, frame_start, locked, err_cnt, frame_crc, crc_valid
   );

   modport slave (
      input  p_tick, hsync, vsync, rgb,
      output x, y, pix_rgb, pix_valid, frame_start, locked, err_cnt, frame_crc, crc_valid
   );
endinterface

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: samples hsync/vsync/rgb on p_tick, recovers x/y,
// locks to the frame structure and counts timing faults while locked.
// Optional feature macro: VGA_RX_CRC_EN adds a CRC-16-CCITT of each fully
// locked frame's visible pixels; without it frame_crc/crc_valid tie to 0.
module vga_timing_receiver #(
   parameter int H_ACTIVE    = 640,
   parameter int H_BP        = 48,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_BP        = 33,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input logic                  clk,
   input logic                  rst,
   vga_timing_receiver_if.slave bus
);
   localparam int GF_W = $clog2(LOCK_FRAMES + 1);

   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

   state_t          state;
   logic            hs_q, vs_q;
   logic [9:0]      h_cnt, v_cnt;
   logic [9:0]      h_nxt, v_nxt;
   logic [GF_W-1:0] good_frames;
   logic            skip_line;
   logic            h_rise, v_rise;
   logic            line_bad, frame_bad, line_chk;
   logic            pix_fire;

   assign h_rise = bus.hsync & ~hs_q;
   assign v_rise = bus.vsync & ~vs_q;

   // Next counter values and fault/window decodes, all relative to this sample
   always_comb begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
      if (h_rise)                h_nxt = '0;
      else if (h_cnt != 10'h3FF) h_nxt = h_cnt + 10'd1;
      if (v_rise)                          v_nxt = '0;
      else if (h_rise && v_cnt != 10'h3FF) v_nxt = v_cnt + 10'd1;
      // a saturated counter yields length 1024, which can never match
      line_bad  = h_rise && (({1'b0, h_cnt} + 11'd1) != 11'(H_TOTAL));
      frame_bad = v_rise && (({1'b0, v_cnt} + 11'd1) != 11'(V_TOTAL));
      // the first line seen after entering ACQUIRE may be a partial one
      line_chk  = line_bad && !(state == ACQUIRE && skip_line);
      pix_fire  = bus.locked &&
                  (h_nxt >= 10'(H_BP)) && (h_nxt < 10'(H_BP + H_ACTIVE)) &&
                  (v_nxt >= 10'(V_BP)) && (v_nxt < 10'(V_BP + V_ACTIVE));
   end

   // Sync edge history and position counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (bus.p_tick) begin
         hs_q  <= bus.hsync;
         vs_q  <= bus.vsync;
         h_cnt <= h_nxt;
         v_cnt <= v_nxt;
      end
   end

   // Pixel capture and frame strobe; strobes last one clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.x           <= '0;
         bus.y           <= '0;
         bus.pix_rgb     <= '0;
         bus.pix_valid   <= 1'b0;
         bus.frame_start <= 1'b0;
      end else begin
         bus.pix_valid   <= 1'b0;
         bus.frame_start <= 1'b0;
         if (bus.p_tick) begin
            if (v_rise) bus.frame_start <= 1'b1;
            if (pix_fire) begin
               bus.x         <= h_nxt - 10'(H_BP);
               bus.y         <= v_nxt - 10'(V_BP);
               bus.pix_rgb   <= bus.rgb;
               bus.pix_valid <= 1'b1;
            end
         end
      end
   end

   // Lock FSM with registered locked flag and saturating error counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= UNLOCKED;
         good_frames <= '0;
         skip_line   <= 1'b0;
         bus.locked  <= 1'b0;
         bus.err_cnt <= '0;
      end else if (bus.p_tick) begin
         case (state)
            UNLOCKED: begin
               if (v_rise) begin
                  state       <= ACQUIRE;
                  good_frames <= '0;
                  skip_line   <= 1'b1;
               end
            end
            ACQUIRE: begin
               if (h_rise) skip_line <= 1'b0;
               if (line_chk || frame_bad) begin
                  state <= UNLOCKED;
               end else if (v_rise) begin
                  good_frames <= good_frames + 1'b1;
                  if (good_frames == GF_W'(LOCK_FRAMES - 1)) begin
                     state      <= LOCKED;
                     bus.locked <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               // a bad line landing on v_rise is still a single error
               if (line_bad || frame_bad) begin
                  state      <= UNLOCKED;
                  bus.locked <= 1'b0;
                  if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
               end
            end
            default: begin
               state      <= UNLOCKED;
               bus.locked <= 1'b0;
            end
         endcase
      end
   end

`ifdef VGA_RX_CRC_EN
   logic [15:0] crc_acc;
   logic        crc_ok;

   // CRC-16-CCITT, 12 data bits folded MSB first in a single step
   function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 11; i >= 0; i--)
         r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction

   // Per-frame accumulation; publish only frames that stayed locked throughout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_acc       <= 16'hFFFF;
         crc_ok        <= 1'b0;
         bus.frame_crc <= '0;
         bus.crc_valid <= 1'b0;
      end else begin
         bus.crc_valid <= 1'b0;
         if (bus.p_tick) begin
            if (v_rise) begin
               crc_acc <= 16'hFFFF;
               crc_ok  <= 1'b1;
               if (crc_ok && bus.locked) begin
                  bus.frame_crc <= crc_acc;
                  bus.crc_valid <= 1'b1;
               end
            end else begin
               if (pix_fire)    crc_acc <= crc12(crc_acc, bus.rgb);
               if (!bus.locked) crc_ok  <= 1'b0;
            end
         end
      end
   end
`else
   assign bus.frame_crc = '0;
   assign bus.crc_valid = 1'b0;
`endif

endmodule
